// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions: divider FSM states, counter sizing
// and a sign-magnitude helper usable by any operand width up to 32 bits.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    // Widest operand the helpers below are written for.
    localparam int ARITH_MAX_W = 32;

    // Iteration counter width for an n-bit divider ($clog2(n)+1).
    function automatic int div_cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

    // Magnitude of a sign-extended operand, one bit wider than the input so
    // the most negative value is representable. Callers truncate to N+1 bits.
    function automatic logic [ARITH_MAX_W:0] abs_ext(input logic [ARITH_MAX_W-1:0] x);
        logic [ARITH_MAX_W:0] xs;
        xs = {x[ARITH_MAX_W-1], x};
        return x[ARITH_MAX_W-1] ? ((ARITH_MAX_W+1)'(0) - xs) : xs;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor magnitude and keep the difference only when it is non-negative.
module div_step #(
    parameter int N = 10
) (
    input  logic [N:0] rem_i,
    input  logic       bit_i,
    input  logic [N:0] dmag_i,
    output logic [N:0] rem_o,
    output logic       qbit_o
);

    logic [N:0]   shifted;
    logic [N+1:0] trial;

    // The partial remainder always stays below |divisor| <= 2^(N-1), so the
    // bit shifted out of the top is guaranteed zero and can be dropped.
    always_comb begin
        shifted = (N+1)'({rem_i, bit_i});
        trial   = {1'b0, shifted} - {1'b0, dmag_i};
        qbit_o  = ~trial[N+1];
        rem_o   = qbit_o ? trial[N:0] : shifted;
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative signed divider: restoring radix-2 on magnitudes, one quotient bit
// per cycle, then a single sign-correction cycle. Valid/ready on both sides.
module seq_divider
    import arith_pkg::*;
#(
    parameter int N = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero,
    output logic         overflow
);

    localparam int           CW      = div_cnt_w(N);
    localparam logic [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};

    div_state_t  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N:0]    rem_q, rem_d;
    logic [N-1:0]  quo_q, quo_d;
    logic [N:0]    dmag_q, dmag_d;
    logic          neg_rem_q, neg_rem_d;
    logic          neg_quo_q, neg_quo_d;
    logic          ovf_pend_q, ovf_pend_d;
    logic [N-1:0]  quotient_q, quotient_d;
    logic [N-1:0]  remainder_q, remainder_d;
    logic          dbz_q, dbz_d;
    logic          ovf_q, ovf_d;

    logic [N-1:0]  dvd_mag;
    logic [N:0]    dvs_mag;
    logic [N:0]    step_rem;
    logic          step_qbit;
    logic          accept;
    logic          handoff;

    // |dividend| <= 2^(N-1) always fits in N unsigned bits.
    assign dvd_mag = N'(abs_ext(32'(signed'(dividend))));
    assign dvs_mag = (N+1)'(abs_ext(32'(signed'(divisor))));

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign accept      = in_valid && in_ready;
    assign handoff     = out_valid && out_ready;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

    div_step #(.N(N)) u_step (
        .rem_i  (rem_q),
        .bit_i  (quo_q[N-1]),
        .dmag_i (dmag_q),
        .rem_o  (step_rem),
        .qbit_o (step_qbit)
    );

    // Next-state logic: accept, iterate, sign-correct, hold until consumed.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dmag_d      = dmag_q;
        neg_rem_d   = neg_rem_q;
        neg_quo_d   = neg_quo_q;
        ovf_pend_d  = ovf_pend_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    // quo_q doubles as the dividend shift register: its MSB
                    // feeds the step while quotient bits enter at the LSB.
                    quo_d      = dvd_mag;
                    dmag_d     = dvs_mag;
                    rem_d      = '0;
                    cnt_d      = '0;
                    neg_rem_d  = dividend[N-1];
                    neg_quo_d  = dividend[N-1] ^ divisor[N-1];
                    ovf_pend_d = (dividend == MIN_VAL) && (divisor == '1);
                    if (divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        ovf_d       = 1'b0;
                        state_d     = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = {quo_q[N-2:0], step_qbit};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N-1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                // MIN/-1 yields magnitude 2^(N-1) with no negation, which
                // already reads back as MIN in N bits: the wrap is natural.
                quotient_d  = neg_quo_q ? (N'(0) - quo_q) : quo_q;
                remainder_d = neg_rem_q ? (N'(0) - N'(rem_q)) : N'(rem_q);
                ovf_d       = ovf_pend_q;
                dbz_d       = 1'b0;
                state_d     = DONE;
            end
            DONE: begin
                if (handoff) begin
                    dbz_d   = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dmag_q      <= '0;
            neg_rem_q   <= 1'b0;
            neg_quo_q   <= 1'b0;
            ovf_pend_q  <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dmag_q      <= dmag_d;
            neg_rem_q   <= neg_rem_d;
            neg_quo_q   <= neg_quo_d;
            ovf_pend_q  <= ovf_pend_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed sign/boundary cases, reset abort,
// backpressure, and random operands against an integer-arithmetic model.
module tb_seq_divider;

    localparam int N = 10;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] dividend = '0;
    logic [N-1:0] divisor = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;

    int n_checks = 0;
    int n_fail   = 0;

    seq_divider #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one division, check result, optional backpressure, then handoff.
    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input int hold);
        int           ai, bi, lat;
        logic [N-1:0] eq, er;
        logic         edbz, eovf;
        logic [N-1:0] sq, sr;

        ai = int'(signed'(a));
        bi = int'(signed'(b));
        edbz = 1'b0;
        eovf = 1'b0;
        if (bi == 0) begin
            eq   = '1;
            er   = a;
            edbz = 1'b1;
        end else if (ai == -(1 << (N-1)) && bi == -1) begin
            eq   = N'(ai);
            er   = '0;
            eovf = 1'b1;
        end else begin
            eq = N'(ai / bi);
            er = N'(ai % bi);
        end

        @(negedge clk);
        chk("in_ready_before", 32'(in_ready), 32'd1);
        dividend  = a;
        divisor   = b;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = N'($urandom);
        divisor  = N'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) chk("out_valid_timeout", 32'd0, 32'd1);
        chk("latency", 32'(lat), (bi == 0) ? 32'd1 : 32'(N + 2));
        chk("quotient", 32'(quotient), 32'(eq));
        chk("remainder", 32'(remainder), 32'(er));
        chk("div_by_zero", 32'(div_by_zero), 32'(edbz));
        chk("overflow", 32'(overflow), 32'(eovf));
        if (bi != 0 && !eovf)
            chk("q_times_d", 32'(N'(int'(signed'(quotient)) * bi)),
                32'(N'(ai - int'(signed'(remainder)))));
        $display("op %0d / %0d -> q=%0d r=%0d dbz=%0b ovf=%0b lat=%0d hold=%0d",
                 ai, bi, int'(signed'(quotient)), int'(signed'(remainder)),
                 div_by_zero, overflow, lat, hold);
        sq = quotient;
        sr = remainder;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            dividend = N'($urandom);
            divisor  = N'($urandom);
            @(posedge clk);
            #1;
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_quotient", 32'(quotient), 32'(sq));
            chk("bp_remainder", 32'(remainder), 32'(sr));
            chk("bp_flags", {30'd0, div_by_zero, overflow}, {30'd0, edbz, eovf});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_out_valid", 32'(out_valid), 32'd0);
        chk("post_in_ready", 32'(in_ready), 32'd1);
        chk("post_flags", {30'd0, div_by_zero, overflow}, 32'd0);
    endtask

    initial begin
        logic [N-1:0] ra, rb;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_quotient", 32'(quotient), 32'd0);
        chk("rst_remainder", 32'(remainder), 32'd0);
        chk("rst_flags", {30'd0, div_by_zero, overflow}, 32'd0);
        rst = 1'b0;

        // Sign cases leave non-zero outputs behind for the reset-abort test.
        do_op(N'(-100), N'(7), 0);
        do_op(N'(100), N'(-7), 0);
        do_op(N'(-100), N'(-7), 0);
        do_op(N'(-403), N'(13), 0);

        // Reset in the middle of 400/3.
        @(negedge clk);
        dividend = N'(400);
        divisor  = N'(3);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_quotient", 32'(quotient), 32'd0);
        chk("abort_remainder", 32'(remainder), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("abort_no_result", 32'(out_valid), 32'd0);
        end
        do_op(N'(248), N'(54), 0);

        // Boundaries and special results.
        do_op(N'(123), N'(0), 0);
        do_op(N'(-512), N'(-1), 0);
        do_op(N'(511), N'(1), 0);
        do_op(N'(1), N'(-512), 0);
        do_op(N'(-512), N'(0), 2);
        do_op(N'(-512), N'(1), 0);
        do_op(N'(-77), N'(5), 5);

        // Random signed operands with a non-zero divisor.
        for (int i = 0; i < 40; i++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            if (rb == '0) rb = N'(1);
            do_op(ra, rb, int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
